fas_freq_analyzer: RTL

//  Analysis stage of the FAS datapath, directly downstream of the 16-point FFT.
//  - Snapshots the 16 complex FFT bins on each fft_valid.
//  - Scans the bins one per cycle, computing |X|^2 = re^2 + im^2.
//  - Reports the index of the largest bin on freq with a one-cycle done pulse.
//  - Sustains one frame every 16 cycles, matching the FFT output rate.

---
 rtl/fas_pkg.sv | 20 ++
 rtl/fas_freq_analyzer_if.sv | 25 ++
 rtl/fas_mag_sq.sv | 17 +
 rtl/fas_freq_analyzer.sv | 98 +++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS analysis stage: bin count, sample width,
// complex sample layout and the scan FSM encoding.
package fas_pkg;

  localparam int N_BINS = 16;
  localparam int DW     = 16;
  localparam int IDX_W  = 4;
  localparam int MAG_W  = 2 * DW;

  // Real part occupies the upper half so a raw 32-bit bin word casts directly.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SCAN = 1'b1;

endpackage

// File: rtl/fas_freq_analyzer_if.sv
// Bin-frame input and peak-report output bundle of the frequency analyzer.
// Handshake: fft_valid is a single-cycle strobe with no ready; the analyzer
// always accepts a frame, and done/overrun are one-cycle result strobes.
interface fas_freq_analyzer_if;
  import fas_pkg::*;

  logic                            fft_valid;
  logic [N_BINS-1:0][2*DW-1:0]     fft_d;
  logic                            done;
  logic [IDX_W-1:0]                freq;
  logic [MAG_W-1:0]                max_mag;
  logic                            overrun;
  state_t                          dbg_state;

  modport master (
    output fft_valid, fft_d,
    input  done, freq, max_mag, overrun, dbg_state
  );

  modport slave (
    input  fft_valid, fft_d,
    output done, freq, max_mag, overrun, dbg_state
  );

endinterface

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one complex sample.
// The sum peaks at 2^31 (both parts -32768), so it fits unsigned MAG_W.
module fas_mag_sq
  import fas_pkg::*;
(
  input  cplx_t             c_i,
  output logic [MAG_W-1:0]  mag_o
);

  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  assign re_sq = c_i.re * c_i.re;
  assign im_sq = c_i.im * c_i.im;
  assign mag_o = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_freq_analyzer.sv
// Peak-bin finder: captures a 16-bin FFT frame, scans one bin per cycle and
// reports the lowest index holding the largest |X|^2.
module fas_freq_analyzer
  import fas_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fas_freq_analyzer_if.slave   bus
);

  state_t            state_q;
  logic              pending_q;
  logic [IDX_W-1:0]  idx_q;
  cplx_t             cap_bank_q  [N_BINS];
  cplx_t             work_bank_q [N_BINS];
  logic [MAG_W-1:0]  run_max_q;
  logic [IDX_W-1:0]  run_idx_q;
  logic              done_q;
  logic [IDX_W-1:0]  freq_q;
  logic [MAG_W-1:0]  max_mag_q;
  logic              overrun_q;

  logic              idx_last;
  logic              start;
  logic              better;
  logic [MAG_W-1:0]  mag;

  fas_mag_sq u_mag (
    .c_i   (work_bank_q[idx_q]),
    .mag_o (mag)
  );

  assign idx_last = (state_q == SCAN) && (idx_q == IDX_W'(N_BINS - 1));
  // A queued frame may start from idle or back-to-back on the last scan cycle.
  assign start    = pending_q && ((state_q == IDLE) || idx_last);
  assign better   = mag > run_max_q;

  // Data banks carry no reset; nothing reads them before a start loads them.
  always_ff @(posedge clk) begin
    if (bus.fft_valid) begin
      for (int k = 0; k < N_BINS; k++) begin
        cap_bank_q[k] <= cplx_t'(bus.fft_d[k]);
      end
    end
    if (start) begin
      work_bank_q <= cap_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      done_q    <= 1'b0;
      freq_q    <= '0;
      max_mag_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= bus.fft_valid && pending_q && !start;
      // A frame arriving on the start edge stays queued behind the one leaving.
      pending_q <= bus.fft_valid || (pending_q && !start);

      if (start) begin
        state_q <= SCAN;
        idx_q   <= '0;
      end else if (state_q == SCAN) begin
        idx_q <= idx_q + 1'b1;
        if (idx_last) begin
          state_q <= IDLE;
        end
      end

      if (state_q == SCAN) begin
        // Strict compare keeps the earliest index on ties.
        if ((idx_q == '0) || better) begin
          run_max_q <= mag;
          run_idx_q <= idx_q;
        end
        if (idx_last) begin
          done_q    <= 1'b1;
          freq_q    <= better ? idx_q : run_idx_q;
          max_mag_q <= better ? mag   : run_max_q;
        end
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.freq      = freq_q;
  assign bus.max_mag   = max_mag_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

endmodule
